// File: rtl/line_double_buffer_if.sv
// Pixel-side handshake bundle for line_double_buffer: write/read strobes in, read data and status out.
interface line_double_buffer_if #(
    parameter int unsigned DW = 8
);
    logic          wce;
    logic [DW-1:0] wd;
    logic          wline;
    logic          rce;
    logic          rline;
    logic [DW-1:0] rd;
    logic          rvalid;
    logic          wbank;
    logic          ovf;

    modport master (
        output wce, wd, wline, rce, rline,
        input  rd, rvalid, wbank, ovf
    );

    modport slave (
        input  wce, wd, wline, rce, rline,
        output rd, rvalid, wbank, ovf
    );
endinterface

// File: rtl/line_double_buffer.sv
// Ping-pong line buffer for the scan doubler: one bank fills with line N while line N-1
// is read back any number of times from the other bank.
module line_double_buffer #(
    parameter int unsigned   DW    = 8,
    parameter int unsigned   AW    = 9,
    parameter logic [DW-1:0] BLANK = '0
) (
    input logic                 clk,
    input logic                 rst,
    line_double_buffer_if.slave bus
);
    localparam int unsigned Depth = 1 << AW;
    localparam logic [AW:0] Full  = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [0:2*Depth-1];

    logic          wbank_q, wbank_d;
    logic [AW:0]   waddr_q, waddr_d;
    logic [AW:0]   wlen_q, wlen_d;
    logic          rbank_q, rbank_d;
    logic [AW:0]   raddr_q, raddr_d;
    logic [AW:0]   rlen_q, rlen_d;
    logic [DW-1:0] rd_q;
    logic          rvalid_q;
    logic          ovf_q, ovf_d;

    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic          eff_bank;
    logic [AW:0]   eff_addr;
    logic [AW:0]   eff_len;
    logic          rd_hit;
    logic [AW:0]   rd_addr;

    always_comb begin
        wbank_d = wbank_q;
        waddr_d = waddr_q;
        wlen_d  = wlen_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_addr = {wbank_q, waddr_q[AW-1:0]};
        if (bus.wline) begin
            wlen_d  = waddr_q;
            wbank_d = ~wbank_q;
            if (bus.wce) begin
                wr_en   = 1'b1;
                wr_addr = {~wbank_q, {AW{1'b0}}};
                waddr_d = {{AW{1'b0}}, 1'b1};
            end else begin
                waddr_d = '0;
            end
        end else if (bus.wce) begin
            if (waddr_q != Full) begin
                wr_en   = 1'b1;
                waddr_d = waddr_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // A line-restart coinciding with a line-close reads the bank and length just closed.
    always_comb begin
        eff_bank = rbank_q;
        eff_len  = rlen_q;
        eff_addr = raddr_q;
        if (bus.rline) begin
            eff_bank = bus.wline ? wbank_q : ~wbank_q;
            eff_len  = bus.wline ? waddr_q : wlen_q;
            eff_addr = '0;
        end
        rd_hit  = bus.rce && (eff_addr < eff_len);
        rd_addr = {eff_bank, eff_addr[AW-1:0]};
        rbank_d = eff_bank;
        rlen_d  = eff_len;
        raddr_d = rd_hit ? eff_addr + 1'b1 : eff_addr;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= bus.wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q  <= 1'b0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            rbank_q  <= 1'b1;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rd_q     <= BLANK;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbank_q <= wbank_d;
            waddr_q <= waddr_d;
            wlen_q  <= wlen_d;
            rbank_q <= rbank_d;
            raddr_q <= raddr_d;
            rlen_q  <= rlen_d;
            ovf_q   <= ovf_d;
            if (bus.rce) begin
                rvalid_q <= rd_hit;
                rd_q     <= rd_hit ? mem[rd_addr] : BLANK;
            end
        end
    end

    assign bus.rd     = rd_q;
    assign bus.rvalid = rvalid_q;
    assign bus.wbank  = wbank_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: doc/line_double_buffer.md
Name: line_double_buffer

Overview:
Parametrised ping-pong line buffer for the video scan doubler. It is the generalised replacement for the fixed 512x8 scan-doubler RAM wrapper. Input pixels for line N are written into one bank while line N-1 is read from the other bank. Each stored line can be read any number of times (normally twice, at 2x pixel rate). The block tracks line length, blanks reads past the stored length, and flags write overflow.

Parameters:
DW, 8, pixel data width
AW, 9, address width; each bank holds 2^AW pixels
BLANK, 0, DW-bit value driven on O_RD when no valid data

Ports:
I_CLK  in  1  system clock; all logic on rising edge
I_RST  in  1  reset, synchronous, active-high
I_WCE  in  1  input pixel strobe: write I_WD this cycle
I_WD  in  DW  input pixel data
I_WLINE  in  1  single-cycle pulse: close current input line, swap banks
I_RCE  in  1  output pixel strobe: read next pixel
I_RLINE  in  1  single-cycle pulse: restart reading at pixel 0 of latest completed line
O_RD  out  DW  registered output pixel
O_RVALID  out  1  O_RD holds stored data (not BLANK)
O_WBANK  out  1  bank currently being written
O_OVF  out  1  sticky: a write was dropped because the bank was full

Behaviour:
- Storage: 2 x 2^AW x DW, synchronous dual-port (one write port, one read port). Address is {bank, addr}. Read and write always target different banks, so there are no read-during-write hazards. Contents are not reset.
- Registers:
  - wbank (1b), waddr (AW+1 b, saturating), wlen (AW+1 b)
  - rbank (1b), raddr (AW+1 b), rlen (AW+1 b)
  - O_RD, O_RVALID, O_OVF
- Reset (I_RST=1 at an edge): wbank=0, rbank=1, waddr=raddr=wlen=rlen=0, O_RD=BLANK, O_RVALID=0, O_OVF=0. Reset overrides all other inputs. Reset mid-line discards the partial line, and rlen=0 guarantees no stale data is output.
- Write side, per edge with I_RST=0:
  - If I_WLINE: wlen<=waddr, wbank<=~wbank. If I_WCE is also set, the pixel goes to addr 0 of the new bank and waddr<=1; otherwise waddr<=0.
  - Else if I_WCE and waddr<2^AW: mem[{wbank,waddr}]<=I_WD, waddr<=waddr+1.
  - Else if I_WCE and waddr==2^AW: the write is dropped, O_OVF<=1 (sticky until reset), waddr holds.
- Read side, per edge with I_RST=0:
  - If I_RLINE: rbank<=(new value of ~wbank), i.e. the bank just completed. If I_WLINE is in the same cycle, use the bank closed by that pulse. rlen<=the new wlen, forwarded when I_WLINE coincides. raddr<=0.
  - If I_RLINE and I_RCE together: pixel 0 of the new line is read and raddr<=1.
  - I_RCE alone with raddr<rlen: read {rbank,raddr}, raddr<=raddr+1. One cycle later O_RD=data and O_RVALID=1.
  - I_RCE alone with raddr>=rlen: O_RD<=BLANK and O_RVALID<=0 one cycle later. raddr holds, with no wrap-around.
  - Cycles without I_RCE: O_RD and O_RVALID hold their previous values.
- Latency: exactly 1 cycle from I_RCE to O_RD/O_RVALID.
- Zero-length line (I_WLINE with waddr=0): wlen=0, and every read of that line returns BLANK.
- Consecutive I_RLINE pulses without an intervening I_WLINE re-read the same line. This is the normal doubling case.
- Arithmetic: all counters are unsigned AW+1 bits. Comparisons are unsigned, and no counter ever exceeds 2^AW.

Test Plan:
1. Basic doubling (AW=9): write 4 pixels 0x11,0x22,0x33,0x44, then pulse I_WLINE. Pulse I_RLINE and strobe I_RCE 4 times, then repeat. Required: O_RD=11,22,33,44 with O_RVALID=1 both times, each 1 cycle after its strobe.
2. Past end of line: after scenario 1, strobe I_RCE 2 more times. Required: O_RD=BLANK and O_RVALID=0 both times; raddr stays 4.
3. Overflow (AW=3): write 10 pixels 0..9, pulse I_WLINE, then read. Required: O_OVF=1 from the 9th write onward; reading returns 0..7 followed by BLANK.
4. Simultaneous events: I_WLINE, I_RLINE, I_WCE and I_RCE all asserted in one cycle after line A (length 3) is written. Required: the read returns line A pixel 0, and the new pixel lands at addr 0 of the other bank (visible after the next I_WLINE/I_RLINE).
5. Reset mid-operation: write 5 pixels, assert I_RST for 1 cycle, then I_RLINE plus 3 I_RCE strobes. Required: all outputs BLANK/0, O_OVF=0, O_WBANK=0.
6. Zero-length line: two I_WLINE pulses with no writes between them, then I_RLINE and I_RCE. Required: O_RD=BLANK, O_RVALID=0.
